serial_adder_ctrl: RTL

Bit-serial adder controller that sequences a single `full_adder` instance over `WIDTH` clock cycles to add two `WIDTH`-bit operands plus a carry-in. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. It trades `WIDTH`× latency for one-bit datapath area. It processes one operation at a time, with no overlap between accept and deliver.

---
 rtl/serial_adder_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full_adder sequenced over WIDTH cycles,
// valid/ready handshakes on operand and result sides, one operation at a time.

module full_adder (
  input  logic in1,
  input  logic in2,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = in1 ^ in2 ^ cin;
  assign cout = (in1 & in2) | (cin & (in1 ^ in2));
endmodule

module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             fa_sum, fa_cout;
  logic [WIDTH-1:0] sum_next;
  logic             last_bit;

  full_adder u_fa (
    .in1  (a_q[0]),
    .in2  (b_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign sum_next = {fa_sum, sum_q[WIDTH-1:1]};
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  // Handshake outputs come straight from the state register.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      out_sum  <= '0;
      out_cout <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= in_a;
            b_q     <= in_b;
            carry_q <= in_cin;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          a_q     <= {1'b0, a_q[WIDTH-1:1]};
          b_q     <= {1'b0, b_q[WIDTH-1:1]};
          sum_q   <= sum_next;
          carry_q <= fa_cout;
          cnt_q   <= cnt_q + CW'(1);
          // Final bit: capture the fully shifted sum, not the stale sum_q.
          if (last_bit) begin
            out_sum  <= sum_next;
            out_cout <= fa_cout;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
